// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int         FRAME_DATA_BITS = 8;
  localparam logic [3:0] STOP_EDGE       = 4'd10;
  localparam logic [3:0] ACK_EDGE        = 4'd11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Odd parity bit: makes the total count of ones in data plus parity odd.
  function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_fall.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a registered clock falling-edge pulse.
// Latency: levels 2 cycles after the pin, fall pulse 3 cycles after the pin edge.
// Backpressure: none; free-running.
module ps2_sync_fall (
  input  logic posclk,
  input  logic reset,
  input  logic i_clk_pin,
  input  logic i_data_pin,
  output logic o_clk_level,
  output logic o_data_level,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;
  logic       r_fall;

  // Synchronize both pins (idle-high after reset) and register a one-cycle pulse on a clock 1->0 step.
  always_ff @(posedge posclk) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_clk_pin};
      r_data_sync <= {r_data_sync[0], i_data_pin};
      r_clk_prev  <= r_clk_sync[1];
      r_fall      <= r_clk_prev & ~r_clk_sync[1];
    end
  end

  assign o_clk_level  = r_clk_sync[1];
  assign o_data_level = r_data_sync[1];
  assign o_clk_fall   = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift on device clock falls, check ACK.
// Latency: INHIBIT_CYCLES + 1 cycles to request-to-send, then paced by the device clock; done 1 cycle after bus idle.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored. Optional watchdog macro: PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       posclk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       kbclk_in,
  input  logic       kbdata_in,
  output logic       kbclk_drive_low,
  output logic       kbdata_drive_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;

  ps2_state_t                 r_state;
  logic [FRAME_DATA_BITS:0]   r_shift;     // data byte with parity on top, shifted out LSB first
  logic [3:0]                 r_edge_cnt;
  logic [INH_W-1:0]           r_inh_cnt;
  logic                       r_err;
  logic                       r_clk_low;
  logic                       r_data_low;
  logic                       r_tx_ready;
  logic                       r_busy;
  logic                       r_tx_done;
  logic                       r_tx_err;

  logic w_clk_level;
  logic w_data_level;
  logic w_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] r_wd_cnt;
`endif

  ps2_sync_fall u_sync (
    .posclk       (posclk),
    .reset        (reset),
    .i_clk_pin    (kbclk_in),
    .i_data_pin   (kbdata_in),
    .o_clk_level  (w_clk_level),
    .o_data_level (w_data_level),
    .o_clk_fall   (w_fall)
  );

  // Frame sequencer; every pin drive and status output is a register updated here.
  always_ff @(posedge posclk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_inh_cnt  <= '0;
      r_err      <= 1'b0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          if (tx_valid && r_tx_ready) begin
            r_shift    <= {odd_parity(tx_data), tx_data};
            r_inh_cnt  <= '0;
            r_err      <= 1'b0;
            r_clk_low  <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= INHIBIT;
          end else begin
            // Ready returns one cycle after the done pulse, not together with it.
            r_tx_ready <= 1'b1;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            r_data_low <= 1'b1;
            r_state    <= RTS;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        RTS: begin
          // Releasing the clock with data still low presents the start bit.
          r_clk_low  <= 1'b0;
          r_edge_cnt <= '0;
          r_state    <= SEND;
        end
        SEND: begin
          if (w_fall) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (r_edge_cnt == STOP_EDGE - 4'd1) begin
              r_data_low <= 1'b0;
              r_state    <= ACK;
            end else begin
              r_data_low <= ~r_shift[0];
              r_shift    <= {1'b1, r_shift[FRAME_DATA_BITS:1]};
            end
          end
        end
        ACK: begin
          if (w_fall) begin
            r_err      <= w_data_level;
            r_edge_cnt <= ACK_EDGE;
            r_state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (w_clk_level && w_data_level) begin
            r_tx_done <= 1'b1;
            r_tx_err  <= r_err;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides the sequencer when the device stops clocking.
      if (r_state == SEND || r_state == ACK || r_state == WAIT_IDLE) begin
        if (w_fall) begin
          r_wd_cnt <= '0;
        end else if (r_wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_wd_cnt   <= '0;
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_tx_done  <= 1'b1;
          r_tx_err   <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
`endif
    end
  end

  assign tx_ready         = r_tx_ready;
  assign busy             = r_busy;
  assign tx_done          = r_tx_done;
  assign tx_err           = r_tx_err;
  assign kbclk_drive_low  = r_clk_low;
  assign kbdata_drive_low = r_data_low;

endmodule
